// File: rtl/ps2_per.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ps2_per                                                     |
// | Function : PS/2 receive peripheral. It synchronizes the device        |
// |            clock and data, deframes 11-bit frames, queues the bytes    |
// |            in a small FIFO, and serves reads and writes from the       |
// |            peripheral bus. It holds sticky frame-error and overflow    |
// |            flags.                                                      |
// | Options  : define PS2_PARITY_CHK_EN to reject bytes with bad odd       |
// |            parity. Without it, the parity bit is sampled and ignored.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ps2_per #(
  parameter logic [3:0]  PER_ADDR   = 4'h3,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic        fastClk,
  input  logic        rstN,
  input  logic        ps2Clk,
  input  logic        ps2Dat,
  input  logic [22:0] pData,
  output logic [16:0] pResp,
  output logic        irq
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  state_t          rState, wStateNext;
  logic            rClkS1, rClkS2, rClkPrev, rDatS1, rDatS2;
  logic [2:0]      rBitCnt;
  logic [7:0]      rShift;
  logic [15:0]     rTmoCnt;
  logic [7:0]      rMem [FIFO_DEPTH];
  logic [AW-1:0]   rWrPtr, rRdPtr;
  logic [3:0]      rCount;
  logic            rPerr, rOvf;
  logic [16:0]     rResp;
  logic            wFall, wDat, wTmoHit, wPush, wFrameErr, wParityOk;
  logic            wReq, wPop, wDoPush, wOvfSet, wEmpty, wFull, wWrite;
  logic [1:0]      wOp;
  logic [7:0]      wStatus, wRdData;
  logic            unusedBits;

  assign wDat    = rDatS2;
  assign wFall   = rClkPrev & ~rClkS2;
  assign wTmoHit = (rState != IDLE) && !wFall && (rTmoCnt == TIMEOUT - 16'd1);

`ifdef PS2_PARITY_CHK_EN
  logic rParity;
  assign wParityOk = ^{rShift, rParity};
`else
  assign wParityOk = 1'b1;
`endif

  // Two-flop synchronizers plus a history flop for falling-edge detection
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN) begin
      rClkS1   <= 1'b1;
      rClkS2   <= 1'b1;
      rClkPrev <= 1'b1;
      rDatS1   <= 1'b1;
      rDatS2   <= 1'b1;
    end else begin
      rClkS1   <= ps2Clk;
      rClkS2   <= rClkS1;
      rClkPrev <= rClkS2;
      rDatS1   <= ps2Dat;
      rDatS2   <= rDatS1;
    end
  end

  // Frame state register
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN) rState <= IDLE;
    else       rState <= wStateNext;
  end

  // Next-state logic; push or reject the byte when the stop bit arrives
  always_comb begin
    wStateNext = rState;
    wPush      = 1'b0;
    wFrameErr  = 1'b0;
    if (wTmoHit) begin
      wStateNext = IDLE;
    end else if (wFall) begin
      case (rState)
        IDLE:    if (!wDat) wStateNext = DATA;
        DATA:    if (rBitCnt == 3'd7) wStateNext = PARITY;
        PARITY:  wStateNext = STOP;
        STOP: begin
          wStateNext = IDLE;
          if (wDat && wParityOk) wPush     = 1'b1;
          else                   wFrameErr = 1'b1;
        end
        default: wStateNext = IDLE;
      endcase
    end
  end

  // Shift in data bits LSB first and capture the parity bit
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN) begin
      rBitCnt <= 3'd0;
      rShift  <= 8'h00;
`ifdef PS2_PARITY_CHK_EN
      rParity <= 1'b0;
`endif
    end else if (wFall) begin
      case (rState)
        IDLE: rBitCnt <= 3'd0;
        DATA: begin
          rShift  <= {wDat, rShift[7:1]};
          rBitCnt <= rBitCnt + 3'd1;
        end
`ifdef PS2_PARITY_CHK_EN
        PARITY: rParity <= wDat;
`endif
        default: ;
      endcase
    end
  end

  // Inactivity timer: it runs only mid-frame and restarts on every falling edge
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN)                                 rTmoCnt <= 16'd0;
    else if (rState == IDLE || wFall || wTmoHit) rTmoCnt <= 16'd0;
    else                                       rTmoCnt <= rTmoCnt + 16'd1;
  end

  assign wOp     = pData[21:20];
  assign wReq    = pData[22] && (pData[19:16] == PER_ADDR);
  assign wWrite  = wReq && (wOp == 2'b10);
  assign wEmpty  = (rCount == 4'd0);
  assign wFull   = (rCount == DEPTH_C);
  assign wPop    = wReq && (wOp == 2'b01) && !wEmpty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign wDoPush = wPush && (!wFull || wPop);
  assign wOvfSet = wPush && wFull && !wPop;
  assign wStatus = {wEmpty, wFull, rPerr, rOvf, rCount};
  assign wRdData = wPop ? rMem[rRdPtr] : 8'h00;

  // FIFO storage
  always_ff @(posedge fastClk) begin
    if (wDoPush) rMem[rWrPtr] <= rShift;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCount <= 4'd0;
    end else begin
      if (wDoPush) rWrPtr <= rWrPtr + AW'(1);
      if (wPop)    rRdPtr <= rRdPtr + AW'(1);
      case ({wDoPush, wPop})
        2'b10:   rCount <= rCount + 4'd1;
        2'b01:   rCount <= rCount - 4'd1;
        default: ;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear takes priority
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN) begin
      rPerr <= 1'b0;
      rOvf  <= 1'b0;
    end else begin
      rPerr <= wFrameErr | (rPerr & ~(wWrite & pData[0]));
      rOvf  <= wOvfSet   | (rOvf  & ~(wWrite & pData[1]));
    end
  end

  // One-cycle registered response for every accepted non-idle request
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN)                       rResp <= 17'd0;
    else if (wReq && wOp != 2'b00)   rResp <= {1'b1, wStatus, wRdData};
    else                             rResp <= 17'd0;
  end

  assign pResp      = rResp;
  assign irq        = !wEmpty;
  assign unusedBits = ^pData[15:2];

endmodule
`default_nettype wire
